// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial word receiver.
package serial_rx_pkg;

  typedef enum logic {
    IDLE,
    RECV
  } rx_state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_shifter.sv
// Serial-in shift register; load starts a fresh word with one bit,
// shift appends a bit from the end selected by dir.
module sipo_shifter
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             dir,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_shift_val;

  always_comb begin
    w_load_val  = '0;
    w_shift_val = r_q;
    if (dir == DIR_LSB_FIRST) begin
      w_load_val[WIDTH-1] = bit_in;
      w_shift_val = {bit_in, r_q[WIDTH-1:1]};
    end else begin
      w_load_val[0] = bit_in;
      w_shift_val = {r_q[WIDTH-2:0], bit_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= w_load_val;
    end else if (shift) begin
      r_q <= w_shift_val;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with valid/ready output,
// overrun and mid-word frame restart detection.
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] data_output,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  rx_state_t        r_state;
  rx_state_t        w_state_n;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_n;
  logic             r_dir;
  logic             w_dir_n;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_n;
  logic             r_valid;
  logic             w_valid_n;
  logic             r_ovr;
  logic             w_ovr_n;
  logic             r_ferr;
  logic             w_ferr_n;

  logic             w_load;
  logic             w_shift;
  logic             w_done;
  logic             w_fire;
  logic             w_sh_dir;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_word;

  assign w_load  = bit_valid & frame_start;
  assign w_shift = bit_valid & ~frame_start
                 & (r_state == RECV);
  assign w_done  = w_shift
                 & (r_count == CNT_W'(WIDTH - 1));
  assign w_fire  = r_valid & out_ready;
  assign w_sh_dir = w_load ? lsb_first : r_dir;

  sipo_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .clock (clock),
    .reset (reset),
    .load  (w_load),
    .shift (w_shift),
    .dir   (w_sh_dir),
    .bit_in(bit_in),
    .q     (w_q)
  );

  // The completing bit is not yet in the shifter, so merge it here.
  always_comb begin
    if (r_dir == DIR_LSB_FIRST) begin
      w_word = {bit_in, w_q[WIDTH-1:1]};
    end else begin
      w_word = {w_q[WIDTH-2:0], bit_in};
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_count_n = r_count;
    w_dir_n   = r_dir;
    w_ferr_n  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_n = RECV;
          w_count_n = CNT_W'(1);
          w_dir_n   = lsb_first;
        end
      end
      RECV: begin
        if (w_load) begin
          w_count_n = CNT_W'(1);
          w_dir_n   = lsb_first;
          w_ferr_n  = 1'b1;
        end else if (w_done) begin
          w_state_n = IDLE;
          w_count_n = '0;
        end else if (w_shift) begin
          w_count_n = r_count + CNT_W'(1);
        end
      end
      default: begin
        w_state_n = IDLE;
        w_count_n = '0;
      end
    endcase
  end

  always_comb begin
    w_data_n  = r_data;
    w_valid_n = r_valid;
    w_ovr_n   = 1'b0;
    if (w_done) begin
      if (r_valid && !out_ready) begin
        w_ovr_n = 1'b1;
      end else begin
        w_data_n  = w_word;
        w_valid_n = 1'b1;
      end
    end else if (w_fire) begin
      w_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_dir   <= DIR_MSB_FIRST;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_dir   <= w_dir_n;
      r_data  <= w_data_n;
      r_valid <= w_valid_n;
      r_ovr   <= w_ovr_n;
      r_ferr  <= w_ferr_n;
    end
  end

  assign data_output = r_data;
  assign out_valid   = r_valid;
  assign busy        = (r_state == RECV);
  assign overrun     = r_ovr;
  assign frame_err   = r_ferr;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed plus randomized bench for serial_word_receiver against
// a word-level model built from bit lists.
module tb_serial_word_receiver;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         frame_start = 1'b0;
  logic         lsb_first = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] data_output;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;

  always #5 clock = ~clock;

  serial_word_receiver #(
    .WIDTH(W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .lsb_first  (lsb_first),
    .data_output(data_output),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  int n_pass = 0;
  int n_total = 0;

  bit           mq[$];
  bit           m_lsb;
  bit           m_busy;
  bit           m_valid;
  bit           m_ovr;
  bit           m_ferr;
  logic [W-1:0] m_data;
  logic [W-1:0] acc[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_lsb = 1'b0;
    m_busy = 1'b0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    m_data = '0;
  endtask

  // Bit k of the frame lands at weight k (LSB-first) or W-1-k.
  function automatic logic [W-1:0] pack_word();
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      if (m_lsb) w[k] = mq[k];
      else w[W-1-k] = mq[k];
    end
    return w;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".data"}, 32'(data_output), 32'(m_data));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".ferr"}, 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic step(input bit bv, input bit fs,
                      input bit b, input bit lsb,
                      input bit rdy);
    bit           done;
    logic [W-1:0] word;
    @(negedge clock);
    bit_valid = bv;
    frame_start = fs;
    bit_in = b;
    lsb_first = lsb;
    out_ready = rdy;
    done = 1'b0;
    word = '0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    if (m_valid && rdy) acc.push_back(m_data);
    if (bv && fs) begin
      if (m_busy) m_ferr = 1'b1;
      mq.delete();
      mq.push_back(b);
      m_lsb = lsb;
      m_busy = 1'b1;
    end else if (bv && m_busy) begin
      mq.push_back(b);
      if (mq.size() == W) begin
        done = 1'b1;
        word = pack_word();
        mq.delete();
        m_busy = 1'b0;
      end
    end
    if (done) begin
      if (m_valid && !rdy) begin
        m_ovr = 1'b1;
      end else begin
        m_data = word;
        m_valid = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
    check_all("step");
  endtask

  task automatic send_word(input logic [W-1:0] w,
                           input bit lsb,
                           input bit rdy,
                           input bit rdy_last);
    for (int i = 0; i < W; i++) begin
      step(1'b1, i == 0,
           lsb ? w[i] : w[W-1-i], lsb,
           (i == W - 1) ? rdy_last : rdy);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    send_word(4'hB, 1'b0, 1'b0, 1'b0);
    chk("t1_data", 32'(data_output), 32'hB);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_busy", 32'(busy), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < W; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_busy_gap", 32'(busy), 32'h1);
      step(1'b1, 1'b0, i != 1, 1'b0, 1'b0);
    end
    chk("t2_data", 32'(data_output), 32'hD);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    acc.delete();
    send_word(4'h5, 1'b0, 1'b1, 1'b1);
    send_word(4'hA, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_count", 32'(acc.size()), 32'd2);
    if (acc.size() == 2) begin
      chk("t3_first", 32'(acc[0]), 32'h5);
      chk("t3_second", 32'(acc[1]), 32'hA);
    end

    send_word(4'h6, 1'b0, 1'b0, 1'b0);
    send_word(4'h9, 1'b0, 1'b0, 1'b1);
    chk("t3b_data", 32'(data_output), 32'h9);
    chk("t3b_valid", 32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    send_word(4'h3, 1'b0, 1'b0, 1'b0);
    send_word(4'hC, 1'b0, 1'b0, 1'b0);
    chk("t4_ovr", 32'(overrun), 32'h1);
    chk("t4_data", 32'(data_output), 32'h3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_ovr_drop", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_ferr", 32'(frame_err), 32'h1);
    for (int i = 1; i < W; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t5_ferr_low", 32'(frame_err), 32'h0);
    end
    chk("t5_data", 32'(data_output), 32'hF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    model_reset();
    check_all("t6_rst");
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < W + 1; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_data", 32'(data_output), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);

    repeat (600) begin
      step($urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 2,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
